regfile_write_sched: RTL and testbench
======================================

// Module: regfile_write_sched
// PURPOSE
//  Write-port controller/arbiter for the 32-entry MIPS register file, which has one write port and no reset.
//  After reset it sequences a clear pass (writes 0 to every register), then shares the write port between two
//  writeback requesters: ALU (A) and memory/load (M). Output is a registered write command to the register file.
//  Sits between the execute/memory writeback stages and the register file.
// PARAMETERS
//  DATA_W  32  width of one register / write data
//  ADDR_W  5   register address width
//  N_REGS  32  registers cleared during init (<= 2**ADDR_W)
// PORTS
//  clk         in   1       clock, all logic on rising edge
//  arst        in   1       reset: synchronous, active-high
//  a_valid     in   1       ALU writeback request
//  a_addr      in   ADDR_W  ALU destination register
//  a_data      in   DATA_W  ALU result
//  a_ready     out  1       ALU request accepted this cycle (valid&ready = transfer)
//  m_valid     in   1       memory writeback request
//  m_addr      in   ADDR_W  memory destination register
//  m_data      in   DATA_W  load data
//  m_ready     out  1       memory request accepted this cycle
//  rf_w_en     out  1       register file write enable
//  rf_addr_w   out  ADDR_W  register file write address
//  rf_w_data   out  DATA_W  register file write data
//  init_done   out  1       1 once clear pass complete
//  rd_addr_1   in   ADDR_W  read-port-1 address (forwarding compare)
//  rd_addr_2   in   ADDR_W  read-port-2 address (forwarding compare)
//  fwd_hit_1   out  1       rd_addr_1 matches write in flight
//  fwd_hit_2   out  1       rd_addr_2 matches write in flight
//  fwd_data    out  DATA_W  data of write in flight (= rf_w_data)
// BEHAVIOUR
//  - Reset (arst=1 at edge): state=CLEAR, clr_cnt=0, rr_ptr=A, rf_w_en=0, rf_addr_w=0, rf_w_data=0, init_done=0.
//    Reset asserted mid-clear or mid-operation aborts everything; clear restarts from reg 0, no pending request kept.
//  - CLEAR: each cycle rf_w_en=1, rf_addr_w=clr_cnt, rf_w_data=0, clr_cnt++. Takes N_REGS cycles (regs 0..N_REGS-1).
//    After writing N_REGS-1, next state RUN, init_done=1 (registered, high the cycle after the last clear write).
//    a_ready=m_ready=0 throughout CLEAR and in the reset cycle.
//  - RUN: ready combinational from valids and rr_ptr; at most one grant per cycle.
//    only A valid -> a_ready=1; only M valid -> m_ready=1; neither -> no grant.
//    both valid -> grant side given by rr_ptr; after a conflict grant rr_ptr flips to the other side.
//    rr_ptr unchanged on non-conflict cycles. Losing requester must hold valid/addr/data; it is granted next cycle.
//    Max wait for any held request: 1 cycle.
//  - Latency 1: a transfer at edge N drives rf_w_en/rf_addr_w/rf_w_data during cycle N+1; no transfer -> rf_w_en=0
//    (addr/data hold last value).
//  - Address 0 ($zero): transfer completes (ready=1), but rf_w_en stays 0; reg 0 is never written in RUN.
//  - Same address from A and M together: arbitrated as normal; both writes land in grant order (last wins).
//  - ready never depends on data or address; valid must not depend on ready.
// CONFIGURATION
//  Macro REGFILE_FWD_EN:
//   defined   -> fwd_hit_k = rf_w_en & (rd_addr_k == rf_addr_w) & (rd_addr_k != 0); fwd_data = rf_w_data.
//                Covers read-during-write: the register file returns old data when read and write hit the same cycle.
//   undefined -> fwd_hit_1=fwd_hit_2=0, fwd_data=0; rd_addr_* unused.
//  fwd_hit_* is 0 during CLEAR in both builds.
// TESTING
//  1. arst 1 cycle, then idle -> rf_w_en=1 for exactly 32 cycles, addr 0..31, data 0; init_done=1 the cycle after
//     addr 31; a_ready=m_ready=0 throughout.
//  2. RUN, a_valid only, addr=5, data=32'hDEADBEEF -> a_ready=1 same cycle; next cycle rf_w_en=1, rf_addr_w=5,
//     rf_w_data=32'hDEADBEEF.
//  3. RUN, A and M valid together 4 cycles (A addr 3, M addr 4), each dropped after its transfer, then re-raised
//     -> grants alternate A,M,A,M; rf_addr_w sequence 3,4,3,4.
//  4. m_valid, m_addr=0, data=1 -> m_ready=1, rf_w_en stays 0 next cycle.
//  5. arst asserted at clear count 10 and while A is waiting on a conflict -> clear restarts at addr 0, A not
//     granted until init_done=1, rr_ptr=A.
//  6. REGFILE_FWD_EN: write addr 7 data 9 in flight, rd_addr_1=7, rd_addr_2=0 -> fwd_hit_1=1, fwd_hit_2=0,
//     fwd_data=9; without macro both hits 0.

Source files
------------

// File: rtl/regfile_write_sched.sv
// Write-port sequencer/arbiter for the 32-entry register file: clear pass after reset, then A/M round-robin writeback.
// Optional read-port forwarding compare is enabled by defining REGFILE_FWD_EN.
module regfile_write_sched #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int N_REGS = 32
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              m_valid,
  input  logic [ADDR_W-1:0] m_addr,
  input  logic [DATA_W-1:0] m_data,
  output logic              m_ready,
  output logic              rf_w_en,
  output logic [ADDR_W-1:0] rf_addr_w,
  output logic [DATA_W-1:0] rf_w_data,
  output logic              init_done,
  input  logic [ADDR_W-1:0] rd_addr_1,
  input  logic [ADDR_W-1:0] rd_addr_2,
  output logic              fwd_hit_1,
  output logic              fwd_hit_2,
  output logic [DATA_W-1:0] fwd_data
);

  typedef enum logic {CLEAR, RUN} state_t;

  localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(N_REGS - 1);

  state_t            state, state_next;
  logic [ADDR_W-1:0] clr_cnt;
  logic              rr_ptr;
  logic              run_ok;
  logic              conflict;

  // Grants are only issued once the clear pass has been acknowledged by init_done.
  always_comb begin
    state_next = state;
    run_ok     = 1'b0;
    conflict   = 1'b0;
    a_ready    = 1'b0;
    m_ready    = 1'b0;
    if (state == CLEAR && clr_cnt == LAST_REG) begin
      state_next = RUN;
    end
    run_ok   = (state == RUN) && init_done && !arst;
    conflict = a_valid && m_valid;
    a_ready  = run_ok && a_valid && (!m_valid || !rr_ptr);
    m_ready  = run_ok && m_valid && (!a_valid || rr_ptr);
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      state     <= CLEAR;
      clr_cnt   <= '0;
      rr_ptr    <= 1'b0;
      rf_w_en   <= 1'b0;
      rf_addr_w <= '0;
      rf_w_data <= '0;
      init_done <= 1'b0;
    end else begin
      state <= state_next;
      if (state == CLEAR) begin
        rf_w_en   <= 1'b1;
        rf_addr_w <= clr_cnt;
        rf_w_data <= '0;
        clr_cnt   <= clr_cnt + 1'b1;
      end else begin
        init_done <= 1'b1;
        if (run_ok && conflict) begin
          rr_ptr <= ~rr_ptr;
        end
        // $zero accepts the transfer but is never written; addr/data keep their last value.
        if (a_ready) begin
          rf_w_en <= (a_addr != '0);
          if (a_addr != '0) begin
            rf_addr_w <= a_addr;
            rf_w_data <= a_data;
          end
        end else if (m_ready) begin
          rf_w_en <= (m_addr != '0);
          if (m_addr != '0) begin
            rf_addr_w <= m_addr;
            rf_w_data <= m_data;
          end
        end else begin
          rf_w_en <= 1'b0;
        end
      end
    end
  end

`ifdef REGFILE_FWD_EN
  // Register file returns stale data on read-during-write, so the in-flight write is forwarded.
  assign fwd_hit_1 = init_done && rf_w_en && (rd_addr_1 == rf_addr_w) && (rd_addr_1 != '0);
  assign fwd_hit_2 = init_done && rf_w_en && (rd_addr_2 == rf_addr_w) && (rd_addr_2 != '0);
  assign fwd_data  = rf_w_data;
`else
  logic unused_rd;
  assign unused_rd = ^{rd_addr_1, rd_addr_2};
  assign fwd_hit_1 = 1'b0;
  assign fwd_hit_2 = 1'b0;
  assign fwd_data  = '0;
`endif

endmodule

// File: tb/tb_regfile_write_sched.sv
// Scoreboard bench for regfile_write_sched: clear pass, arbitration, $zero handling, reset abort, forwarding.
module tb_regfile_write_sched;

`ifdef REGFILE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        arst;
  logic        a_valid, m_valid;
  logic [4:0]  a_addr, m_addr;
  logic [31:0] a_data, m_data;
  logic        a_ready, m_ready;
  logic        rf_w_en;
  logic [4:0]  rf_addr_w;
  logic [31:0] rf_w_data;
  logic        init_done;
  logic [4:0]  rd_addr_1, rd_addr_2;
  logic        fwd_hit_1, fwd_hit_2;
  logic [31:0] fwd_data;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t sb[$];
  int  checks   = 0;
  int  failures = 0;
  bit  model_rr  = 1'b0;
  bit  model_run = 1'b0;

  regfile_write_sched dut (
    .clk(clk), .arst(arst),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .m_valid(m_valid), .m_addr(m_addr), .m_data(m_data), .m_ready(m_ready),
    .rf_w_en(rf_w_en), .rf_addr_w(rf_addr_w), .rf_w_data(rf_w_data),
    .init_done(init_done),
    .rd_addr_1(rd_addr_1), .rd_addr_2(rd_addr_2),
    .fwd_hit_1(fwd_hit_1), .fwd_hit_2(fwd_hit_2), .fwd_data(fwd_data)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called at a negedge: compares the write in flight against the scoreboard head.
  task automatic checkWrite();
    wr_t  w;
    logic have;
    logic h1, h2;
    have = 1'b0;
    w.addr = '0;
    w.data = '0;
    if (sb.size() > 0) begin
      w = sb.pop_front();
      have = 1'b1;
    end
    checkOutput("rf_w_en", 64'(rf_w_en), 64'(have));
    if (have) begin
      checkOutput("rf_addr_w", 64'(rf_addr_w), 64'(w.addr));
      checkOutput("rf_w_data", 64'(rf_w_data), 64'(w.data));
      checkOutput("fwd_data", 64'(fwd_data), FWD ? 64'(w.data) : 64'(0));
    end else if (!FWD) begin
      checkOutput("fwd_data_off", 64'(fwd_data), 64'(0));
    end
    h1 = FWD && have && (rd_addr_1 == w.addr) && (rd_addr_1 != 5'd0);
    h2 = FWD && have && (rd_addr_2 == w.addr) && (rd_addr_2 != 5'd0);
    checkOutput("fwd_hit_1", 64'(fwd_hit_1), 64'(h1));
    checkOutput("fwd_hit_2", 64'(fwd_hit_2), 64'(h2));
  endtask

  // Drives one cycle of requests at a negedge, checks grants against the round-robin model, then the write.
  task automatic applyStimulus(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                               input logic mv, input logic [4:0] ma, input logic [31:0] md);
    logic ga, gm;
    wr_t  w;
    a_valid = av; a_addr = aa; a_data = ad;
    m_valid = mv; m_addr = ma; m_data = md;
    #1;
    ga = model_run && av && (!mv || !model_rr);
    gm = model_run && mv && (!av || model_rr);
    checkOutput("a_ready", 64'(a_ready), 64'(ga));
    checkOutput("m_ready", 64'(m_ready), 64'(gm));
    if (ga && aa != 5'd0) begin
      w.addr = aa; w.data = ad; sb.push_back(w);
    end else if (gm && ma != 5'd0) begin
      w.addr = ma; w.data = md; sb.push_back(w);
    end
    if (model_run && av && mv) model_rr = !model_rr;
    @(posedge clk);
    @(negedge clk);
    checkWrite();
  endtask

  task automatic doReset();
    arst = 1'b1;
    #1;
    checkOutput("rst_a_ready", 64'(a_ready), 64'(0));
    checkOutput("rst_m_ready", 64'(m_ready), 64'(0));
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst_w_en", 64'(rf_w_en), 64'(0));
    checkOutput("rst_addr", 64'(rf_addr_w), 64'(0));
    checkOutput("rst_data", 64'(rf_w_data), 64'(0));
    checkOutput("rst_init_done", 64'(init_done), 64'(0));
    arst = 1'b0;
    sb.delete();
    model_rr  = 1'b0;
    model_run = 1'b0;
  endtask

  // Checks n clear writes; a full pass (32) also checks the init_done cycle that follows.
  task automatic runClear(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput("clr_w_en", 64'(rf_w_en), 64'(1));
      checkOutput("clr_addr", 64'(rf_addr_w), 64'(k));
      checkOutput("clr_data", 64'(rf_w_data), 64'(0));
      checkOutput("clr_init_done", 64'(init_done), 64'(0));
      checkOutput("clr_a_ready", 64'(a_ready), 64'(0));
      checkOutput("clr_m_ready", 64'(m_ready), 64'(0));
      checkOutput("clr_fwd_hit_1", 64'(fwd_hit_1), 64'(0));
    end
    if (n == 32) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput("init_done", 64'(init_done), 64'(1));
      checkOutput("post_clr_w_en", 64'(rf_w_en), 64'(0));
      model_run = 1'b1;
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    arst = 1'b1;
    a_valid = 1'b0; a_addr = '0; a_data = '0;
    m_valid = 1'b0; m_addr = '0; m_data = '0;
    rd_addr_1 = 5'd5; rd_addr_2 = 5'd0;
    @(negedge clk);

    $display("[TB] reset and clear pass");
    doReset();
    runClear(32);

    $display("[TB] single ALU write");
    applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

    $display("[TB] alternating conflicts");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 5'd3, 32'hA000 + i, 1'b1, 5'd4, 32'hB000 + i);
    end
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

    $display("[TB] zero register and same-address writes");
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'd1);
    applyStimulus(1'b1, 5'd9, 32'd111, 1'b1, 5'd9, 32'd222);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'd222);

    $display("[TB] forwarding compare");
    rd_addr_1 = 5'd7; rd_addr_2 = 5'd0;
    applyStimulus(1'b1, 5'd7, 32'd9, 1'b0, 5'd0, 32'd0);
    rd_addr_1 = 5'd0; rd_addr_2 = 5'd12;
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'h55);

    $display("[TB] random traffic");
    for (int i = 0; i < 40; i++) begin
      rd_addr_1 = 5'($urandom_range(0, 31));
      rd_addr_2 = 5'($urandom_range(0, 3));
      applyStimulus(1'($urandom), 5'($urandom_range(0, 3)), $urandom,
                    1'($urandom), 5'($urandom_range(0, 3)), $urandom);
    end
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

    $display("[TB] reset during clear");
    doReset();
    runClear(10);
    doReset();
    runClear(32);

    $display("[TB] reset while ALU waits on a conflict");
    applyStimulus(1'b1, 5'd1, 32'd11, 1'b1, 5'd2, 32'd22);
    a_valid = 1'b1; a_addr = 5'd6; a_data = 32'd66;
    m_valid = 1'b1; m_addr = 5'd8; m_data = 32'd88;
    #1;
    checkOutput("wait_a_ready", 64'(a_ready), 64'(0));
    checkOutput("wait_m_ready", 64'(m_ready), 64'(1));
    doReset();
    runClear(32);
    applyStimulus(1'b1, 5'd6, 32'd66, 1'b1, 5'd8, 32'd88);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 32'd88);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
